edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel edge-event scheduler placed after the dual-edge detection datapath. It synchronises `CHANNELS` asynchronous inputs and detects any edge (rise or fall) on each. It queues one pending event per channel and serialises the events onto a single shared valid/ready consumer port, granting channels round-robin. It also reports per-channel overruns, where a new edge arrives while that channel's previous event is still undelivered.

## Interface
- `CHANNELS`, default 4: number of input signals; legal range 2..8.
- `CW`, default `$clog2(CHANNELS)`: channel-index width; derived, do not override.

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset; clears all state immediately.
- `sig`, in, `CHANNELS`: raw asynchronous input levels, bit i = channel i.
- `evtReady`, in, 1: consumer accepts the presented event this cycle.
- `evtValid`, out, 1: an event is presented.
- `evtChannel`, out, `CW`: index of the presented channel.
- `evtLevel`, out, 1: channel level after the edge (1 = rising, 0 = falling).
- `overrun`, out, `CHANNELS`: sticky per-channel overrun flags.
- `clearOverrun`, in, `CHANNELS`: synchronous per-bit clear of `overrun`.

## Operation
- Per channel, a 2-flop synchroniser feeds a previous-level register; `edge[i] = sync[i] ^ prev[i]`.
- `edge[i]` sets `pending[i]` and loads `level[i] <= sync[i]`.
- If `pending[i]` is already set and is not being taken into the output register this cycle, `overrun[i]` sets.
  - `level[i]` updates to the newest level.
  - Only one event remains queued.
- Output FSM has two states: IDLE (`evtValid` = 0) and PRESENT (`evtValid` = 1).
- IDLE with any pending:
  - Search channels starting at `last+1` mod `CHANNELS`, wrapping.
  - First pending channel g is loaded: `evtChannel <= g`, `evtLevel <= level[g]`, `pending[g]` cleared, `last <= g`, go to PRESENT.
- PRESENT and `evtReady`: handshake completes.
  - If any channel is pending, reload from the next pending channel in the same cycle and stay in PRESENT. This gives back-to-back delivery.
  - Otherwise go to IDLE.
- PRESENT and not `evtReady`: hold `evtChannel`/`evtLevel` stable. `evtValid` must not drop.
- A load on channel g coinciding with a new edge on g leaves `pending[g]` set with the new level. This is not an overrun.
- If `clearOverrun[i]` and an overrun set occur in the same cycle, set wins.
- Reset values: `evtValid` = 0, `evtChannel` = 0, `evtLevel` = 0, `overrun` = 0, `pending` = 0, `last` = `CHANNELS-1` (so the first search starts at 0).
  - Synchroniser and `prev` registers reset to 0, so an input held high at reset release yields one rising event.
- Reset asserted mid-operation discards all pending and presented events without handshake.

## Timing
- `sig[i]` changing before rising edge k is seen in `sync` at k+1. `pending[i]` sets at k+2. `evtValid` rises at k+3 if IDLE.
- Pulses shorter than one clock period may be missed; this is by design.
- Throughput is one event per cycle while `evtReady` is held high.
- Worst-case wait for a pending channel is `CHANNELS-1` grants.
- All outputs are registered; there is no combinational path from `evtReady` or `sig` to any output.

## Structure
- Shared package `edge_evt_pkg`: FSM state enum (`ST_IDLE`, `ST_PRESENT`), constant `MAX_CHANNELS` = 8.
- Sub-module `edge_detect_cell`, one per channel: synchroniser, `prev`, `edge`, `level`.
- Pending, overrun and round-robin logic stay in the top level.

## Test plan
- Single rise: `sig[2]` 0→1 with `evtReady` = 1 → exactly one event, `evtChannel` = 2, `evtLevel` = 1, `evtValid` high for exactly one cycle, 3 cycles after sampling.
- Simultaneous edges: all 4 channels toggle in the same cycle with `evtReady` = 1 from reset → events in order 0, 1, 2, 3 on consecutive cycles, no overrun.
- Back-pressure: channel 1 rise with `evtReady` = 0 for 5 cycles → `evtChannel`/`evtLevel` stable throughout; channel 1 falls during the stall → second event (1, 0) follows acceptance, no overrun.
- Overrun: during the stall, channel 3 toggles 0→1→0 over 4 cycles → `overrun[3]` = 1, one queued event with `evtLevel` = 0; `clearOverrun[3]` pulse → `overrun[3]` = 0.
- Fairness: channels 0 and 1 toggle every 2 cycles, `evtReady` = 1 → grants alternate 0, 1, 0, 1; channel 0 never delivered twice in a row while 1 is pending.
- Reset mid-event: assert `reset` low while `evtValid` = 1 with 2 pending → `evtValid` = 0 immediately, no events after release until a new edge.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared types and limits for the edge-event arbiter.
package edge_evt_pkg;

    localparam int unsigned MAX_CHANNELS = 8;

    typedef enum logic {ST_IDLE, ST_PRESENT} evt_state_t;

endpackage

// File: rtl/edge_event_arbiter_cell.sv
// Per-channel front end: 2-flop synchroniser, previous level, edge pulse and captured level.
module edge_detect_cell (
    input  logic clk,
    input  logic reset,
    input  logic sig_raw,
    output logic evt_edge,
    output logic level
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level_q;

    assign evt_edge = sync2_q ^ prev_q;
    assign level    = level_q;

    // Reset to 0 so an input held high at reset release yields one rising event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sig_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (evt_edge) begin
                level_q <= sync2_q;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Queues one edge event per channel and serialises them round-robin onto a valid/ready port.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CW       = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] sig,
    input  logic                evtReady,
    output logic                evtValid,
    output logic [CW-1:0]       evtChannel,
    output logic                evtLevel,
    output logic [CHANNELS-1:0] overrun,
    input  logic [CHANNELS-1:0] clearOverrun
);

    if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_param_check
        $error("edge_event_arbiter: CHANNELS out of range");
    end

    logic [CHANNELS-1:0] edge_vec;
    logic [CHANNELS-1:0] level_vec;
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] take_vec;
    logic [CW-1:0]       last_q;
    logic [CW-1:0]       grant;
    logic                found;
    logic                take;
    int unsigned         idx;
    evt_state_t          state_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
        edge_detect_cell u_cell (
            .clk      (clk),
            .reset    (reset),
            .sig_raw  (sig[i]),
            .evt_edge (edge_vec[i]),
            .level    (level_vec[i])
        );
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            idx = (32'(last_q) + k) % CHANNELS;
            if (!found && pending_q[CW'(idx)]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
    end

    assign take = found && (state_q == ST_IDLE || evtReady);

    always_comb begin
        take_vec = '0;
        if (take) begin
            take_vec[grant] = 1'b1;
        end
    end

    // A new edge on a channel being loaded re-arms it without counting as an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            overrun   <= '0;
        end else begin
            pending_q <= (pending_q & ~take_vec) | edge_vec;
            overrun   <= (overrun & ~clearOverrun) | (edge_vec & pending_q & ~take_vec);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            evtValid   <= 1'b0;
            evtChannel <= '0;
            evtLevel   <= 1'b0;
            last_q     <= CW'(CHANNELS - 1);
        end else begin
            if (take) begin
                state_q    <= ST_PRESENT;
                evtValid   <= 1'b1;
                evtChannel <= grant;
                evtLevel   <= level_vec[grant];
                last_q     <= grant;
            end else if (state_q == ST_PRESENT && evtReady) begin
                state_q  <= ST_IDLE;
                evtValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter with 4 channels.
module tb_edge_event_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] sig;
    logic       evtReady;
    logic       evtValid;
    logic [1:0] evtChannel;
    logic       evtLevel;
    logic [3:0] overrun;
    logic [3:0] clearOverrun;

    int tests;
    int failed;

    edge_event_arbiter #(
        .CHANNELS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sig          (sig),
        .evtReady     (evtReady),
        .evtValid     (evtValid),
        .evtChannel   (evtChannel),
        .evtLevel     (evtLevel),
        .overrun      (overrun),
        .clearOverrun (clearOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Applies reset from a negedge with all inputs quiet; returns on a negedge.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        sig          = '0;
        evtReady     = 1'b0;
        clearOverrun = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        reset        = 1'b0;
        sig          = '0;
        evtReady     = 1'b0;
        clearOverrun = '0;

        do_reset();
        check("rst_valid", 32'(evtValid), 0);
        check("rst_chan", 32'(evtChannel), 0);
        check("rst_level", 32'(evtLevel), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Single rise on channel 2: valid for exactly one cycle, 3 cycles after sampling.
        evtReady = 1'b1;
        sig[2]   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("single_valid_%0d", i), 32'(evtValid), (i == 3) ? 1 : 0);
            if (i == 3) begin
                check("single_chan", 32'(evtChannel), 2);
                check("single_level", 32'(evtLevel), 1);
            end
        end

        // All channels toggle together: delivered 0,1,2,3 back to back.
        do_reset();
        evtReady = 1'b1;
        sig      = 4'hf;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("simul_valid_%0d", i), 32'(evtValid), (i >= 3 && i <= 6) ? 1 : 0);
            if (i >= 3 && i <= 6) begin
                check($sformatf("simul_chan_%0d", i), 32'(evtChannel), 32'(i - 3));
                check($sformatf("simul_level_%0d", i), 32'(evtLevel), 1);
            end
        end
        check("simul_overrun", 32'(overrun), 0);

        // Back-pressure: channel 1 rises, stalls 5 cycles, falls during the stall.
        do_reset();
        sig[1] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i >= 3 && i <= 8) begin
                check($sformatf("bp_valid_%0d", i), 32'(evtValid), 1);
                check($sformatf("bp_chan_%0d", i), 32'(evtChannel), 1);
                check($sformatf("bp_level_%0d", i), 32'(evtLevel), 1);
            end
            if (i == 9) begin
                check("bp_second_valid", 32'(evtValid), 1);
                check("bp_second_chan", 32'(evtChannel), 1);
                check("bp_second_level", 32'(evtLevel), 0);
            end
            if (i == 10) check("bp_idle", 32'(evtValid), 0);
            if (i == 4) sig[1] = 1'b0;
            if (i == 8) evtReady = 1'b1;
        end
        check("bp_overrun", 32'(overrun), 0);

        // Overrun: channel 3 pulses high while its first event is still queued.
        do_reset();
        sig[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 7) check("ovr_before", 32'(overrun), 0);
            if (i == 8) begin
                check("ovr_set", 32'(overrun), 32'h8);
                check("ovr_hold_chan", 32'(evtChannel), 1);
            end
            if (i == 9) begin
                check("ovr_evt_valid", 32'(evtValid), 1);
                check("ovr_evt_chan", 32'(evtChannel), 3);
                check("ovr_evt_level", 32'(evtLevel), 0);
            end
            if (i == 10) begin
                check("ovr_single_queued", 32'(evtValid), 0);
                check("ovr_sticky", 32'(overrun), 32'h8);
            end
            if (i == 11) check("ovr_cleared", 32'(overrun), 0);
            if (i == 3) sig[3] = 1'b1;
            if (i == 5) sig[3] = 1'b0;
            if (i == 8) evtReady = 1'b1;
            if (i == 10) clearOverrun[3] = 1'b1;
            if (i == 11) clearOverrun[3] = 1'b0;
        end

        // Fairness: channels 0 and 1 toggle every 2 cycles; grants alternate.
        do_reset();
        evtReady = 1'b1;
        sig[1:0] = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 3 && i <= 10) begin
                check($sformatf("fair_valid_%0d", i), 32'(evtValid), 1);
                check($sformatf("fair_chan_%0d", i), 32'(evtChannel), 32'((i - 3) % 2));
                check($sformatf("fair_level_%0d", i), 32'(evtLevel),
                      (((i - 3) / 2) % 2 == 0) ? 1 : 0);
            end
            if (i == 11) check("fair_idle", 32'(evtValid), 0);
            if (i == 1 || i == 3 || i == 5) sig[1:0] = ~sig[1:0];
        end
        check("fair_overrun", 32'(overrun), 0);

        // Reset while presenting with two more pending.
        do_reset();
        sig = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        check("mid_valid_before", 32'(evtValid), 1);
        check("mid_chan_before", 32'(evtChannel), 0);
        reset = 1'b0;
        #1;
        check("mid_valid_async", 32'(evtValid), 0);
        sig = '0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        evtReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("mid_quiet_%0d", i), 32'(evtValid), 0);
        end
        check("mid_overrun", 32'(overrun), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
